// File: rtl/iter_decoder_if.sv
// Valid/ready block stream and key-write bus for iter_decoder.
// master = producer/sink side, slave = decoder core.
interface iter_decoder_if #(
  parameter int KA_W = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_data;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic            key_we;
  logic [KA_W-1:0] key_addr;
  logic [15:0]     key_wdata;
  logic            key_err;

  modport master (
    output in_valid, in_data, out_ready, key_we, key_addr, key_wdata,
    input  in_ready, out_valid, out_data, key_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, key_we, key_addr, key_wdata,
    output in_ready, out_valid, out_data, key_err
  );
endinterface

// File: rtl/iter_decoder.sv
// Iterative NUM_ROUNDS-round decryptor for the 16-bit nibble cipher (S-AES style inverse ops).
// Optional input whitening is enabled by defining DEC_WHITEN_EN.
module iter_decoder #(
  parameter int NUM_ROUNDS = 4,
  parameter int KA_W       = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  iter_decoder_if.slave bus,
  output logic          busy
`ifdef DEC_WHITEN_EN
  ,
  input  logic [15:0]   whiten_key
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [KA_W-1:0] LAST_RND = KA_W'(NUM_ROUNDS - 1);

  state_e          state_q, state_d;
  logic [15:0]     data_q, data_d;
  logic [KA_W-1:0] rnd_q, rnd_d;
  logic            key_err_q;
  logic [15:0]     key_q [NUM_ROUNDS];

  logic [31:0]     addr_ext;
  logic            addr_ok;
  logic            key_wr_ok;
  logic [KA_W-1:0] key_idx;
  logic [15:0]     load_val;
  logic [15:0]     mc_out, sr_out, sb_out, round_out;

  // GF(2^4) arithmetic, field polynomial x^4 + x + 1
  function automatic logic [3:0] gf_mul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [3:0] gf_mul9(input logic [3:0] a);
    return gf_mul2(gf_mul2(gf_mul2(a))) ^ a;
  endfunction

  // Inverse mix-columns: each column (two nibbles) times [9 2; 2 9]
  function automatic logic [15:0] reverse_mc(input logic [15:0] s);
    return {gf_mul9(s[15:12]) ^ gf_mul2(s[11:8]),
            gf_mul2(s[15:12]) ^ gf_mul9(s[11:8]),
            gf_mul9(s[7:4])   ^ gf_mul2(s[3:0]),
            gf_mul2(s[7:4])   ^ gf_mul9(s[3:0])};
  endfunction

  function automatic logic [15:0] shiftrow(input logic [15:0] s);
    return {s[15:12], s[3:0], s[7:4], s[11:8]};
  endfunction

  function automatic logic [3:0] r_box(input logic [3:0] n);
    logic [3:0] r;
    case (n)
      4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
      4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
      4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
      4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  default: r = 4'hE;
    endcase
    return r;
  endfunction

  assign mc_out = reverse_mc(data_q);
  assign sr_out = shiftrow(mc_out);

  for (genvar gi = 0; gi < 4; gi++) begin : g_rbox
    assign sb_out[4*gi +: 4] = r_box(sr_out[4*gi +: 4]);
  end

  // Keys are consumed last-to-first
  assign key_idx   = LAST_RND - rnd_q;
  assign round_out = sb_out ^ key_q[key_idx];

`ifdef DEC_WHITEN_EN
  assign load_val = bus.in_data ^ whiten_key;
`else
  assign load_val = bus.in_data;
`endif

  assign addr_ext  = 32'(bus.key_addr);
  assign addr_ok   = addr_ext < 32'(NUM_ROUNDS);
  assign key_wr_ok = bus.key_we && (state_q == IDLE) && addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ROUNDS; i++) key_q[i] <= '0;
    end else if (key_wr_ok) begin
      for (int i = 0; i < NUM_ROUNDS; i++) begin
        if (addr_ext == 32'(i)) key_q[i] <= bus.key_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      rnd_q     <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      rnd_q     <= rnd_d;
      key_err_q <= bus.key_we && !key_wr_ok;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d  = load_val;
          rnd_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        data_d = round_out;
        // Leave at the last round so rnd never wraps
        if (rnd_q == LAST_RND) begin
          rnd_d   = '0;
          state_d = DONE;
        end else begin
          rnd_d = rnd_q + KA_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = data_q;
  assign bus.key_err   = key_err_q;
  assign busy          = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_iter_decoder.sv
// Bench for iter_decoder: two instances (4 rounds and 1 round) against a behavioural cipher model.
module tb_iter_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy4, busy1;
  logic [15:0] wk = 16'h0000;
  int checks = 0;
  int errors = 0;
  logic [15:0] mk4 [4];
  logic [15:0] mk1 [4];

  always #5 clk = ~clk;

  iter_decoder_if #(.KA_W(2)) if4 ();
  iter_decoder_if #(.KA_W(1)) if1 ();

  iter_decoder #(.NUM_ROUNDS(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4), .busy(busy4)
`ifdef DEC_WHITEN_EN
    , .whiten_key(wk)
`endif
  );

  iter_decoder #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1), .busy(busy1)
`ifdef DEC_WHITEN_EN
    , .whiten_key(wk)
`endif
  );

  // ---- behavioural model ----
  function automatic logic [3:0] m_gmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'({4'h0, a}) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [3:0] m_inv_sbox(input logic [3:0] n);
    logic [3:0] fwd [16];
    logic [3:0] r;
    fwd = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
            4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
    r = 4'h0;
    for (int j = 0; j < 16; j++) if (fwd[j] == n) r = 4'(j);
    return r;
  endfunction

  function automatic logic [15:0] m_round(input logic [15:0] s, input logic [15:0] k);
    logic [3:0] n [4];
    logic [3:0] m [4];
    logic [3:0] t;
    for (int i = 0; i < 4; i++) n[i] = s[15-4*i -: 4];
    for (int c = 0; c < 2; c++) begin
      m[2*c]   = m_gmul(4'h9, n[2*c]) ^ m_gmul(4'h2, n[2*c+1]);
      m[2*c+1] = m_gmul(4'h2, n[2*c]) ^ m_gmul(4'h9, n[2*c+1]);
    end
    t = m[1]; m[1] = m[3]; m[3] = t;
    for (int i = 0; i < 4; i++) n[i] = m_inv_sbox(m[i]);
    return {n[0], n[1], n[2], n[3]} ^ k;
  endfunction

  function automatic logic [15:0] ref_dec(input logic [15:0] din, input logic [15:0] keys [4],
                                          input int nr, input logic [15:0] w);
    logic [15:0] s;
    s = din ^ w;
    for (int r = 0; r < nr; r++) s = m_round(s, keys[nr-1-r]);
    return s;
  endfunction

  // ---- helpers ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr4(input int addr, input logic [15:0] v, input bit ok);
    if4.key_we = 1'b1; if4.key_addr = 2'(addr); if4.key_wdata = v;
    tick();
    if4.key_we = 1'b0;
    chk("key_err4", 32'(if4.key_err), 32'(!ok));
    if (ok) mk4[addr] = v;
    $display("key4 write addr=%0d data=%h ok=%0d", addr, v, ok);
  endtask

  task automatic wr1(input int addr, input logic [15:0] v, input bit ok);
    if1.key_we = 1'b1; if1.key_addr = 1'(addr); if1.key_wdata = v;
    tick();
    if1.key_we = 1'b0;
    chk("key_err1", 32'(if1.key_err), 32'(!ok));
    if (ok) mk1[addr] = v;
    $display("key1 write addr=%0d data=%h ok=%0d", addr, v, ok);
  endtask

  task automatic blk4(input logic [15:0] din, input int hold);
    logic [15:0] exp;
    int lat;
    exp = ref_dec(din, mk4, 4, wk);
    chk("in_ready4_idle", 32'(if4.in_ready), 32'd1);
    if4.in_valid = 1'b1; if4.in_data = din;
    tick();
    if4.in_valid = 1'b0;
    lat = 0;
    while (!if4.out_valid && lat < 20) begin
      chk("busy4_run", 32'(busy4), 32'd1);
      tick();
      lat++;
    end
    chk("latency4", 32'(lat), 32'd4);
    chk("data4", 32'(if4.out_data), 32'(exp));
    repeat (hold) begin
      tick();
      chk("hold_valid4", 32'(if4.out_valid), 32'd1);
      chk("hold_data4", 32'(if4.out_data), 32'(exp));
      chk("hold_ready4", 32'(if4.in_ready), 32'd0);
    end
    if4.out_ready = 1'b1;
    tick();
    if4.out_ready = 1'b0;
    chk("post_ready4", 32'(if4.in_ready), 32'd1);
    chk("post_valid4", 32'(if4.out_valid), 32'd0);
    $display("blk4 in=%h out=%h exp=%h lat=%0d hold=%0d", din, if4.out_data, exp, lat, hold);
  endtask

  task automatic blk1(input logic [15:0] din);
    logic [15:0] exp;
    exp = ref_dec(din, mk1, 1, wk);
    if1.in_valid = 1'b1; if1.in_data = din;
    tick();
    if1.in_valid = 1'b0;
    chk("run_valid1", 32'(if1.out_valid), 32'd0);
    tick();
    chk("latency1", 32'(if1.out_valid), 32'd1);
    chk("data1", 32'(if1.out_data), 32'(exp));
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
    chk("post_ready1", 32'(if1.in_ready), 32'd1);
    $display("blk1 in=%h out=%h exp=%h", din, if1.out_data, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] save;
    int lat;
    for (int i = 0; i < 4; i++) begin mk4[i] = '0; mk1[i] = '0; end
    if4.in_valid = 0; if4.in_data = 0; if4.out_ready = 0;
    if4.key_we = 0; if4.key_addr = 0; if4.key_wdata = 0;
    if1.in_valid = 0; if1.in_data = 0; if1.out_ready = 0;
    if1.key_we = 0; if1.key_addr = 0; if1.key_wdata = 0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(if4.in_ready), 32'd1);
    chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_key_err", 32'(if4.key_err), 32'd0);
    chk("rst_data", 32'(if4.out_data), 32'd0);
    $display("reset released");

    // 4 rounds, keys 1..4, with 10-cycle backpressure
    for (int i = 0; i < 4; i++) wr4(i, 16'(i + 1), 1'b1);
    blk4(16'hBEEF, 10);

    // Key write during RUN is rejected and leaves the key file alone
    save = ref_dec(16'hBEEF, mk4, 4, wk);
    if4.in_valid = 1'b1; if4.in_data = 16'hBEEF;
    tick();
    if4.in_valid = 1'b0;
    if4.key_we = 1'b1; if4.key_addr = 2'd0; if4.key_wdata = 16'h5555;
    tick();
    if4.key_we = 1'b0;
    chk("key_err_run", 32'(if4.key_err), 32'd1);
    tick();
    chk("key_err_pulse", 32'(if4.key_err), 32'd0);
    lat = 2;
    while (!if4.out_valid && lat < 20) begin tick(); lat++; end
    chk("latency_keyrun", 32'(lat), 32'd4);
    chk("data_keyrun", 32'(if4.out_data), 32'(save));
    if4.out_ready = 1'b1; tick(); if4.out_ready = 1'b0;
    $display("run-time key write rejected, out=%h", if4.out_data);
    blk4(16'hBEEF, 0);

    // Single round: key A5C3, then an out-of-range write
    wr1(0, 16'hA5C3, 1'b1);
    wr1(1, 16'hFFFF, 1'b0);
    tick();
    chk("key_err1_pulse", 32'(if1.key_err), 32'd0);
    blk1(16'h1234);
    blk1(16'h1234);

`ifdef DEC_WHITEN_EN
    wk = 16'hFFFF;
    blk1(16'h1234);
    blk4(16'hBEEF, 1);
    wk = 16'h0000;
`endif

    // Randomized blocks and key updates
    for (int n = 0; n < 12; n++) begin
      wr4(int'($urandom_range(0, 3)), 16'($urandom), 1'b1);
      blk4(16'($urandom), int'($urandom_range(0, 3)));
      if (n % 3 == 0) begin
        wr1(0, 16'($urandom), 1'b1);
        blk1(16'($urandom));
      end
    end

    // Reset in the middle of a block
    if4.in_valid = 1'b1; if4.in_data = 16'hC0DE;
    tick();
    if4.in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(if4.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(if4.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy4), 32'd0);
    chk("midrst_data", 32'(if4.out_data), 32'd0);
    for (int i = 0; i < 4; i++) begin mk4[i] = '0; mk1[i] = '0; end
    $display("mid-block reset applied");
    tick();
    chk("midrst_no_valid", 32'(if4.out_valid), 32'd0);
    blk4(16'($urandom), 0);
    blk1(16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
